// File: rtl/fifo_rd_scheduler.sv
// -----------------------------------------------------------------------------
// fifo_rd_scheduler
//
// Shares one byte consumer between two asynchronous FIFO read ports. The
// scheduler watches both empty flags, grants one FIFO at a time with
// round-robin fairness, and pops up to BURST_LEN bytes per grant. Each popped
// byte is held on a valid/ready output until the consumer takes it.
//
// Handshake: tx_valid is high in SEND. While tx_valid=1 the outputs tx_data
// and tx_src are frozen. A byte transfers on a cycle where tx_valid=1 and
// tx_ready=1; tx_valid drops on the following cycle.
//
// Ports:
//   r_clk, rrst_n       read-domain clock, asynchronous active-low reset
//   sched_en            scheduler enable (never aborts a byte already popped)
//   rempty0/1           FIFO empty flags (lag two cycles behind a pop)
//   rdata0/1            combinational FIFO read data
//   r_inc0/1            one-cycle pop strobes, never both high
//   tx_ready            consumer can accept a byte
//   tx_valid/data/src   byte on offer and the FIFO it came from
//   sched_busy          high in any state other than IDLE
//   dbg_state           current FSM state (0 IDLE, 1 FETCH, 2 SEND, 3 SETTLE)
// -----------------------------------------------------------------------------
module fifo_rd_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  r_clk,
    input  logic                  rrst_n,
    input  logic                  sched_en,
    input  logic                  rempty0,
    input  logic                  rempty1,
    input  logic [DATA_WIDTH-1:0] rdata0,
    input  logic [DATA_WIDTH-1:0] rdata1,
    output logic                  r_inc0,
    output logic                  r_inc1,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_src,
    output logic                  sched_busy,
    output logic [1:0]            dbg_state
);

    localparam logic [3:0] LP_BURST = 4'(BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SEND   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_grant;
    logic                  w_next_grant;
    logic                  r_last_grant;
    logic                  w_next_last_grant;
    logic [3:0]            r_burst_cnt;
    logic [3:0]            w_next_burst_cnt;
    logic                  r_pop0;
    logic                  r_pop1;
    logic                  r_tx_valid;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_src;

    logic                  w_rempty_g;
    logic [DATA_WIDTH-1:0] w_rdata_g;

    assign w_rempty_g = r_grant ? rempty1 : rempty0;
    assign w_rdata_g  = r_grant ? rdata1  : rdata0;

    // Next-state logic. The empty flags are only consulted in IDLE and
    // SETTLE: in SEND the flag of the FIFO just popped is still stale.
    always_comb begin
        w_next_state      = r_state;
        w_next_grant      = r_grant;
        w_next_last_grant = r_last_grant;
        w_next_burst_cnt  = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (sched_en && !(rempty0 && rempty1)) begin
                    w_next_state     = ST_FETCH;
                    w_next_burst_cnt = 4'd0;
                    if (!rempty0 && !rempty1) begin
                        // Contention: take the FIFO not served last.
                        w_next_grant = ~r_last_grant;
                    end else begin
                        // Exactly one non-empty: FIFO1 only if FIFO0 is empty.
                        w_next_grant = rempty0;
                    end
                end
            end
            ST_FETCH: begin
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    w_next_burst_cnt = r_burst_cnt + 4'd1;
                    w_next_state     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (sched_en && (r_burst_cnt < LP_BURST) && !w_rempty_g) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_last_grant = r_grant;
                    w_next_state      = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs. Pop strobes and tx_valid are decoded from
    // the next state so they are high exactly during FETCH and SEND.
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_burst_cnt  <= 4'd0;
            r_pop0       <= 1'b0;
            r_pop1       <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= '0;
            r_tx_src     <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_grant      <= w_next_grant;
            r_last_grant <= w_next_last_grant;
            r_burst_cnt  <= w_next_burst_cnt;
            r_pop0       <= (w_next_state == ST_FETCH) && !w_next_grant;
            r_pop1       <= (w_next_state == ST_FETCH) &&  w_next_grant;
            r_tx_valid   <= (w_next_state == ST_SEND);
            if (r_state == ST_FETCH) begin
                r_tx_data <= w_rdata_g;
                r_tx_src  <= r_grant;
            end
        end
    end

    assign r_inc0     = r_pop0;
    assign r_inc1     = r_pop1;
    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign tx_src     = r_tx_src;
    assign sched_busy = (r_state != ST_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_scheduler
//
// Directed bench for fifo_rd_scheduler. Two FIFO models feed the DUT; their
// empty flags lag a pop by two cycles. A scoreboard holds the expected byte
// stream ({src, data}) and a pop log records the grant order.
// -----------------------------------------------------------------------------
module tb_fifo_rd_scheduler;

    logic       r_clk = 1'b0;
    logic       rrst_n;
    logic       sched_en;
    logic       rempty0;
    logic       rempty1;
    logic [7:0] rdata0;
    logic [7:0] rdata1;
    logic       r_inc0;
    logic       r_inc1;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_src;
    logic       sched_busy;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // ---------------- clock ----------------
    always #5 r_clk = ~r_clk;
    always @(posedge r_clk) cyc <= cyc + 1;

    fifo_rd_scheduler #(
        .DATA_WIDTH (8),
        .BURST_LEN  (4)
    ) dut (
        .r_clk      (r_clk),
        .rrst_n     (rrst_n),
        .sched_en   (sched_en),
        .rempty0    (rempty0),
        .rempty1    (rempty1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .r_inc0     (r_inc0),
        .r_inc1     (r_inc1),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_src     (tx_src),
        .sched_busy (sched_busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- FIFO models ----------------
    logic [7:0] mem0 [0:31];
    logic [7:0] mem1 [0:31];
    logic [5:0] wp0 = '0;
    logic [5:0] wp1 = '0;
    logic [5:0] rp0 = '0;
    logic [5:0] rp1 = '0;
    logic       empty_s0 = 1'b1;
    logic       empty_s1 = 1'b1;

    // One register stage on top of the pointer update: a pop in cycle t is
    // reflected on rempty from cycle t+2.
    always @(posedge r_clk) begin
        if (r_inc0) rp0 <= rp0 + 6'd1;
        if (r_inc1) rp1 <= rp1 + 6'd1;
        empty_s0 <= (wp0 == rp0);
        empty_s1 <= (wp1 == rp1);
    end

    assign rempty0 = empty_s0;
    assign rempty1 = empty_s1;
    assign rdata0  = mem0[rp0[4:0]];
    assign rdata1  = mem1[rp1[4:0]];

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    logic       pop_log[$];
    int         inc0_times[$];
    int         inc0_cnt  = 0;
    int         inc1_cnt  = 0;
    int         deliv_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge r_clk) begin
        if (rrst_n) begin
            if (r_inc0 || r_inc1) check("inc_onehot", {31'd0, r_inc0 & r_inc1}, 32'd0);
            if (r_inc0) begin
                check("overread0", {31'd0, wp0 != rp0}, 32'd1);
                pop_log.push_back(1'b0);
                inc0_times.push_back(cyc);
                inc0_cnt++;
            end
            if (r_inc1) begin
                check("overread1", {31'd0, wp1 != rp1}, 32'd1);
                pop_log.push_back(1'b1);
                inc1_cnt++;
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("tx_byte", {23'd0, tx_src, tx_data}, {23'd0, e});
                end
                deliv_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge r_clk);
        #2;
    endtask

    task automatic push0(input logic [7:0] d);
        mem0[wp0[4:0]] = d;
        wp0 = wp0 + 6'd1;
        exp_q.push_back({1'b0, d});
    endtask

    task automatic push1(input logic [7:0] d);
        mem1[wp1[4:0]] = d;
        wp1 = wp1 + 6'd1;
        exp_q.push_back({1'b1, d});
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge r_clk);
            if (exp_q.size() == 0 && !sched_busy) begin
                done = 1;
                break;
            end
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge r_clk);
            if (tx_valid) begin
                done = 1;
                break;
            end
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int s0;
        int s1;
        int sd;
        logic [8:0] tmp_q[$];

        rrst_n   = 1'b0;
        sched_en = 1'b0;
        tx_ready = 1'b0;

        // Reset values
        tick(3);
        @(negedge r_clk);
        check("rst_tx_valid", {31'd0, tx_valid},   32'd0);
        check("rst_r_inc0",   {31'd0, r_inc0},     32'd0);
        check("rst_r_inc1",   {31'd0, r_inc1},     32'd0);
        check("rst_tx_data",  {24'd0, tx_data},    32'd0);
        check("rst_tx_src",   {31'd0, tx_src},     32'd0);
        check("rst_busy",     {31'd0, sched_busy}, 32'd0);
        check("rst_state",    {30'd0, dbg_state},  32'd0);
        tick(1);
        rrst_n = 1'b1;

        // Single source: FIFO0 holds three bytes, FIFO1 empty
        push0(8'hA1); push0(8'hA2); push0(8'hA3);
        tx_ready = 1'b1;
        tick(3);
        inc0_cnt = 0; inc1_cnt = 0; inc0_times.delete();
        sched_en = 1'b1;
        wait_drain("single_drain", 60);
        check("single_inc0_cnt", 32'(inc0_cnt), 32'd3);
        check("single_inc1_cnt", 32'(inc1_cnt), 32'd0);
        if (inc0_times.size() == 3) begin
            check("single_gap1", 32'(inc0_times[1] - inc0_times[0]), 32'd3);
            check("single_gap2", 32'(inc0_times[2] - inc0_times[1]), 32'd3);
        end

        // Round-robin: fresh reset so FIFO0 wins the first contention
        tick(1);
        sched_en = 1'b0;
        rrst_n   = 1'b0;
        tick(1);
        rrst_n = 1'b1;
        for (int i = 0; i < 4; i++) push0(8'hB0 + 8'(i));
        for (int i = 0; i < 4; i++) push1(8'hC0 + 8'(i));
        for (int i = 4; i < 8; i++) push0(8'hB0 + 8'(i));
        for (int i = 4; i < 8; i++) push1(8'hC0 + 8'(i));
        pop_log.delete();
        tick(3);
        sched_en = 1'b1;
        wait_drain("rr_drain", 200);
        check("rr_pop_count", 32'(pop_log.size()), 32'd16);
        if (pop_log.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check("rr_grant", {31'd0, pop_log[i]}, 32'((i >> 2) & 1));
            end
        end

        // Backpressure: ten cycles of tx_ready=0 during SEND
        tick(1);
        tx_ready = 1'b0;
        push0(8'hD0); push0(8'hD1);
        wait_valid("bp_valid", 20);
        s0 = inc0_cnt + inc1_cnt;
        sd = deliv_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge r_clk);
            check("bp_valid_hold", {31'd0, tx_valid}, 32'd1);
            check("bp_data_hold",  {24'd0, tx_data},  32'hD0);
            check("bp_src_hold",   {31'd0, tx_src},   32'd0);
        end
        check("bp_no_pop",   32'(inc0_cnt + inc1_cnt - s0), 32'd0);
        check("bp_no_deliv", 32'(deliv_cnt - sd), 32'd0);
        tick(1);
        tx_ready = 1'b1;
        wait_drain("bp_drain", 40);
        check("bp_deliv", 32'(deliv_cnt - sd), 32'd2);

        // Last-entry hazard: one byte in FIFO1
        tick(1);
        s1 = inc1_cnt;
        push1(8'hE0);
        tick(2);
        wait_drain("hz_drain", 40);
        tick(4);
        check("hz_inc1_once", 32'(inc1_cnt - s1), 32'd1);
        check("hz_idle", {31'd0, sched_busy}, 32'd0);

        // Enable drop in SEND of byte 2 of a FIFO0 burst
        tx_ready = 1'b0;
        push0(8'h60); push0(8'h61);
        push1(8'h70); push1(8'h71);
        push0(8'h62); push0(8'h63);
        // Expected order: 60,61 (drop) then FIFO1 70,71 then 62,63
        tmp_q = exp_q;
        exp_q.delete();
        exp_q.push_back(tmp_q[0]); exp_q.push_back(tmp_q[1]);
        exp_q.push_back(tmp_q[2]); exp_q.push_back(tmp_q[3]);
        exp_q.push_back(tmp_q[4]); exp_q.push_back(tmp_q[5]);
        wait_valid("en_byte1", 20);
        check("en_byte1_data", {24'd0, tx_data}, 32'h60);
        tick(1);
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        wait_valid("en_byte2", 20);
        check("en_byte2_data", {24'd0, tx_data}, 32'h61);
        s0 = inc0_cnt;
        s1 = inc1_cnt;
        tick(1);
        sched_en = 1'b0;
        tx_ready = 1'b1;
        tick(6);
        check("en_no_pop0", 32'(inc0_cnt - s0), 32'd0);
        check("en_no_pop1", 32'(inc1_cnt - s1), 32'd0);
        check("en_idle",    {31'd0, sched_busy}, 32'd0);
        check("en_left",    32'(exp_q.size()), 32'd4);
        pop_log.delete();
        sched_en = 1'b1;
        wait_drain("en_drain", 60);
        if (pop_log.size() > 0) check("en_resume_fifo1", {31'd0, pop_log[0]}, 32'd1);
        else check("en_resume_pops", 32'(pop_log.size()), 32'd1);

        // Reset mid-SEND: last grant was FIFO0, so FIFO1 goes first
        tick(1);
        tx_ready = 1'b0;
        mem0[wp0[4:0]] = 8'h80; wp0 = wp0 + 6'd1;
        mem0[wp0[4:0]] = 8'h81; wp0 = wp0 + 6'd1;
        mem1[wp1[4:0]] = 8'h90; wp1 = wp1 + 6'd1;
        mem1[wp1[4:0]] = 8'h91; wp1 = wp1 + 6'd1;
        wait_valid("rs_valid", 20);
        check("rs_pre_src",  {31'd0, tx_src},  32'd1);
        check("rs_pre_data", {24'd0, tx_data}, 32'h90);
        tick(1);
        rrst_n = 1'b0;
        #1;
        check("rs_tx_valid", {31'd0, tx_valid},   32'd0);
        check("rs_r_inc0",   {31'd0, r_inc0},     32'd0);
        check("rs_r_inc1",   {31'd0, r_inc1},     32'd0);
        check("rs_busy",     {31'd0, sched_busy}, 32'd0);
        tick(2);
        // 0x90 was popped and discarded by the reset
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b0, 8'h81});
        exp_q.push_back({1'b1, 8'h91});
        pop_log.delete();
        rrst_n   = 1'b1;
        tx_ready = 1'b1;
        wait_drain("rs_drain", 60);
        if (pop_log.size() > 0) check("rs_fifo0_first", {31'd0, pop_log[0]}, 32'd0);
        else check("rs_pops", 32'(pop_log.size()), 32'd1);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
